// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Sequential unsigned restoring divider. One quotient bit is produced per
//   clock using a shift / trial-subtract / restore step, with a
//   start/busy/done handshake. Serves the CPU DIV/MOD operations next to the
//   Booth multiplier.
//
// Ports
//   clk          in   1      single clock, rising-edge
//   reset        in   1      synchronous, active-high
//   start        in   1      request, only honoured in IDLE
//   dividend     in   WIDTH  unsigned dividend, sampled with accepted start
//   divisor      in   WIDTH  unsigned divisor, sampled with accepted start
//   busy         out  1      high while iterating (exactly WIDTH cycles)
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  result, held until the next completion
//   remainder    out  WIDTH  result, held until the next completion
//   div_by_zero  out  1      flagged with done when divisor was zero
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  // The partial remainder is always strictly below the divisor after a step,
  // so only WIDTH bits need to be stored; the extra bit exists only in the
  // shifted/trial values below.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring-division step: shift {A,Q} left, trial-subtract the divisor,
  // keep the difference only when it did not go negative.
  always_comb begin
    acc_sh   = {acc, quo[WIDTH-1]};
    quo_sh   = {quo[WIDTH-2:0], 1'b0};
    trial    = acc_sh - {1'b0, dvs};
    acc_next = acc_sh[WIDTH-1:0];
    quo_next = quo_sh;
    if (trial[WIDTH] == 1'b0) begin
      acc_next = trial[WIDTH-1:0];
      quo_next = quo_sh | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      acc_next = acc_sh[WIDTH-1:0];
      quo_next = quo_sh;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              dvs         <= divisor;
              quo         <= dividend;
              acc         <= '0;
              cnt         <= CW'(WIDTH);
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= CALC;
            end else begin
              // Divide by zero completes immediately with all-ones quotient.
              quotient    <= {WIDTH{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_next;
          quo <= quo_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient  <= quo_next;
            remainder <= acc_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            state <= CALC;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int vectors;
  int miscompares;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: plain; 1: extra start (8/2) pulsed in CALC cycle 2;
  // 2: operand inputs scrambled every cycle after acceptance.
  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input int mode);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edbz;
    int           exp_lat;
    int           exp_busy;
    int           n;
    int           busy_cnt;
    logic         seen;
    if (dv == 0) begin
      eq = {W{1'b1}}; er = dd; edbz = 1'b1; exp_lat = 1; exp_busy = 0;
    end else begin
      eq = dd / dv; er = dd % dv; edbz = 1'b0; exp_lat = W + 1; exp_busy = W;
    end
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 1'b0; n = 0; busy_cnt = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (mode == 1 && n == 2) begin
        start = 1'b1; dividend = 4'd8; divisor = 4'd2;
      end else begin
        start = 1'b0;
      end
      if (mode == 2) begin
        dividend = 4'($urandom_range(0, 15));
        divisor  = 4'($urandom_range(0, 15));
      end
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", n, exp_lat);
    check("busy_cycles", busy_cnt, exp_busy);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edbz));
    if (dv != 0) begin
      check("invariant", int'(quotient) * int'(dv) + int'(remainder), 32'(dd));
      check("rem_lt_div", 32'(remainder < dv), 32'd1);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("result_held", 32'(quotient), 32'(eq));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    // Directed cases
    run_op(4'd13, 4'd3, 0);
    run_op(4'd7, 4'd9, 0);
    run_op(4'd15, 4'd1, 0);
    run_op(4'd15, 4'd15, 0);
    run_op(4'd9, 4'd0, 0);
    run_op(4'd13, 4'd3, 1);

    // Reset during CALC cycle 2: everything clears, no done pulse
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_no_done", 32'(done), 32'd0);
    run_op(4'd6, 4'd4, 0);

    // Exhaustive sweep of nonzero divisors
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 1; dv < 16; dv++) begin
        run_op(4'(dd), 4'(dv), 0);
      end
    end

    // Random operands (zero divisor included), inputs scrambled mid-operation
    for (int k = 0; k < 60; k++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), (k % 2 == 0) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
